// File: rtl/player_physics_if.sv
// Bundle between the gravity/input controller (master) and the vertical-motion
// engine (slave): frame tick, control requests, line map and player state.
interface player_physics_if #(
   parameter int HEIGHT_W  = 9,
   parameter int NUM_LINES = 3,
   parameter int VEL_W     = 4
);
   logic                       tick;
   logic                       restart;
   logic                       is_dead;
   logic                       flip_req;
   logic [NUM_LINES-1:0]       lines;
   logic                       flip_ack;
   logic                       grav_up;
   logic [HEIGHT_W-1:0]        height;
   logic signed [VEL_W-1:0]    velocity;
   logic                       grounded;
   logic                       out_of_bounds;

   modport master (
      output tick, restart, is_dead, flip_req, lines,
      input  flip_ack, grav_up, height, velocity, grounded, out_of_bounds
   );

   modport slave (
      input  tick, restart, is_dead, flip_req, lines,
      output flip_ack, grav_up, height, velocity, grounded, out_of_bounds
   );
endinterface

// File: rtl/player_physics.sv
// Vertical-motion engine for the gravity-flip runner: per-tick velocity update,
// landing on platform lines from either side, flip handshake, out-of-bounds death.
module player_physics #(
   parameter int HEIGHT_W   = 9,
   parameter int NUM_LINES  = 3,
   parameter int LINE_BASE  = 120,
   parameter int LINE_PITCH = 120,
   parameter int PLAYER_H   = 60,
   parameter int START_Y    = 240,
   parameter int MAX_VEL    = 4,
   parameter int Y_MAX      = 479
) (
   input  logic            clk,
   input  logic            rst_n,
   player_physics_if.slave phys
);
   localparam int VEL_W = $clog2(MAX_VEL) + 2;
   localparam int NW    = HEIGHT_W + 2;

   localparam logic signed [VEL_W:0]  V_POS   = 1;
   localparam logic signed [VEL_W:0]  V_NEG   = -1;
   localparam logic signed [VEL_W:0]  V_HI    = MAX_VEL;
   localparam logic signed [VEL_W:0]  V_LO    = -MAX_VEL;
   localparam logic signed [NW-1:0]   TOP_LIM = Y_MAX - PLAYER_H;
   localparam logic [HEIGHT_W-1:0]    START_H = START_Y;

   typedef enum logic [1:0] {AIR, GROUND, DEAD} state_t;

   state_t                  state_reg;
   logic [HEIGHT_W-1:0]     height_reg;
   logic signed [VEL_W-1:0] velocity_reg;
   logic                    grav_up_reg;
   logic                    grounded_reg;
   logic                    oob_reg;
   logic                    flip_ack_reg;

   // Landing surfaces: top of line k when falling, line k minus player height when rising.
   logic signed [NW-1:0] surf_dn [NUM_LINES];
   logic signed [NW-1:0] surf_up [NUM_LINES];
   logic [NUM_LINES-1:0] dn_ok;
   logic [NUM_LINES-1:0] up_ok;

   generate
      for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_surf
         localparam int S = LINE_BASE + gi * LINE_PITCH;
         localparam int C = S - PLAYER_H;
         assign surf_dn[gi] = NW'(S);
         assign surf_up[gi] = NW'(C);
         assign dn_ok[gi]   = (S >= 0) && (S <= Y_MAX);
         assign up_ok[gi]   = (C >= 0) && (C <= Y_MAX);
      end
   endgenerate

   logic signed [VEL_W:0]    v_sum;
   logic signed [VEL_W-1:0]  v_next;
   logic signed [NW-1:0]     cur_s;
   logic signed [NW-1:0]     next_s;
   logic signed [NW-1:0]     best_s;
   logic                     hit;
   logic                     oob_next;

   always_comb begin
      v_sum = $signed({velocity_reg[VEL_W-1], velocity_reg}) + (grav_up_reg ? V_POS : V_NEG);
      if (v_sum > V_HI)
         v_next = V_HI[VEL_W-1:0];
      else if (v_sum < V_LO)
         v_next = V_LO[VEL_W-1:0];
      else
         v_next = v_sum[VEL_W-1:0];

      cur_s  = $signed({2'b00, height_reg});
      next_s = cur_s + NW'(v_next);

      hit    = 1'b0;
      best_s = cur_s;
      for (int k = 0; k < NUM_LINES; k++) begin
         if (!grav_up_reg) begin
            // Falling: the highest crossed surface wins.
            if (phys.lines[k] && dn_ok[k] && cur_s >= surf_dn[k] && next_s <= surf_dn[k]
                && (!hit || surf_dn[k] > best_s)) begin
               hit    = 1'b1;
               best_s = surf_dn[k];
            end
         end else begin
            if (phys.lines[k] && up_ok[k] && cur_s <= surf_up[k] && next_s >= surf_up[k]
                && (!hit || surf_up[k] < best_s)) begin
               hit    = 1'b1;
               best_s = surf_up[k];
            end
         end
      end

      oob_next = next_s[NW-1] || (next_s > TOP_LIM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= AIR;
         height_reg   <= START_H;
         velocity_reg <= '0;
         grav_up_reg  <= 1'b0;
         grounded_reg <= 1'b0;
         oob_reg      <= 1'b0;
         flip_ack_reg <= 1'b0;
      end else begin
         flip_ack_reg <= 1'b0;
         if (phys.restart) begin
            state_reg    <= AIR;
            height_reg   <= START_H;
            velocity_reg <= '0;
            grav_up_reg  <= 1'b0;
            grounded_reg <= 1'b0;
            oob_reg      <= 1'b0;
         end else if (phys.is_dead || state_reg == DEAD) begin
            // Frozen: state held until released or restarted.
         end else if (state_reg == GROUND && phys.flip_req) begin
            grav_up_reg  <= ~grav_up_reg;
            velocity_reg <= '0;
            state_reg    <= AIR;
            grounded_reg <= 1'b0;
            flip_ack_reg <= 1'b1;
         end else if (phys.tick) begin
            if (hit) begin
               height_reg   <= best_s[HEIGHT_W-1:0];
               velocity_reg <= '0;
               state_reg    <= GROUND;
               grounded_reg <= 1'b1;
            end else if (oob_next) begin
               velocity_reg <= '0;
               state_reg    <= DEAD;
               grounded_reg <= 1'b0;
               oob_reg      <= 1'b1;
            end else begin
               height_reg   <= next_s[HEIGHT_W-1:0];
               velocity_reg <= v_next;
               state_reg    <= AIR;
               grounded_reg <= 1'b0;
            end
         end
      end
   end

   assign phys.height        = height_reg;
   assign phys.velocity      = velocity_reg;
   assign phys.grav_up       = grav_up_reg;
   assign phys.grounded      = grounded_reg;
   assign phys.out_of_bounds = oob_reg;
   assign phys.flip_ack      = flip_ack_reg;
endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics: rest, fall/land, flip handshake, fall-out,
// freeze priority and asynchronous reset, with hand-computed expected values.
module tb_player_physics;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   player_physics_if #(.HEIGHT_W(9), .NUM_LINES(3), .VEL_W(4)) bus ();

   player_physics dut (
      .clk   (clk),
      .rst_n (rst_n),
      .phys  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk) bus.tick = 1'b1;
      @(negedge clk) bus.tick = 1'b0;
   endtask

   task automatic pulse_flip();
      @(negedge clk) bus.flip_req = 1'b1;
      @(negedge clk) bus.flip_req = 1'b0;
   endtask

   task automatic pulse_restart();
      @(negedge clk) bus.restart = 1'b1;
      @(negedge clk) bus.restart = 1'b0;
   endtask

   task automatic show(input string what);
      $display("[TB] %s: h=%0d v=%0d up=%0d gnd=%0d oob=%0d ack=%0d", what,
               bus.height, bus.velocity, bus.grav_up, bus.grounded,
               bus.out_of_bounds, bus.flip_ack);
   endtask

   int fall_h [6] = '{239, 237, 234, 230, 226, 222};
   int fall_v [6] = '{-1, -2, -3, -4, -4, -4};
   int rise_h [4] = '{241, 243, 246, 250};

   initial begin
      bus.tick = 1'b0; bus.restart = 1'b0; bus.is_dead = 1'b0;
      bus.flip_req = 1'b0; bus.lines = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      show("reset");
      check_val("rst_height", bus.height, 240);
      check_val("rst_vel", bus.velocity, 0);
      check_val("rst_grav", bus.grav_up, 0);
      check_val("rst_gnd", bus.grounded, 0);
      check_val("rst_oob", bus.out_of_bounds, 0);
      check_val("rst_ack", bus.flip_ack, 0);

      // Rest on line 1
      bus.lines = 3'b010;
      do_tick();
      show("rest");
      check_val("rest_height", bus.height, 240);
      check_val("rest_gnd", bus.grounded, 1);
      check_val("rest_vel", bus.velocity, 0);
      for (int i = 0; i < 10; i++) do_tick();
      show("rest+10");
      check_val("rest10_height", bus.height, 240);
      check_val("rest10_gnd", bus.grounded, 1);

      // Freeze while grounded: flip must not be accepted
      @(negedge clk) begin bus.is_dead = 1'b1; bus.flip_req = 1'b1; end
      @(negedge clk);
      show("dead_flip");
      check_val("dead_flip_ack", bus.flip_ack, 0);
      @(negedge clk) begin bus.is_dead = 1'b0; bus.flip_req = 1'b0; end
      check_val("dead_flip_grav", bus.grav_up, 0);
      check_val("dead_flip_gnd", bus.grounded, 1);

      // Flip handshake
      bus.lines = 3'b111;
      pulse_flip();
      show("flip");
      check_val("flip_ack", bus.flip_ack, 1);
      check_val("flip_grav", bus.grav_up, 1);
      check_val("flip_gnd", bus.grounded, 0);
      check_val("flip_height", bus.height, 240);
      @(negedge clk);
      check_val("flip_ack_once", bus.flip_ack, 0);
      for (int i = 0; i < 4; i++) begin
         do_tick();
         show("rise");
         check_val("rise_height", bus.height, rise_h[i]);
      end
      pulse_flip();
      show("flip_in_air");
      check_val("air_flip_ack", bus.flip_ack, 0);
      check_val("air_flip_grav", bus.grav_up, 1);
      do_tick();
      check_val("rise_254", bus.height, 254);
      for (int i = 0; i < 30 && !bus.grounded; i++) do_tick();
      show("land_up");
      check_val("land_up_gnd", bus.grounded, 1);
      check_val("land_up_height", bus.height, 300);
      check_val("land_up_vel", bus.velocity, 0);

      // Restart, rest on line 1, then fall to line 0
      pulse_restart();
      show("restart");
      check_val("rs_height", bus.height, 240);
      check_val("rs_grav", bus.grav_up, 0);
      bus.lines = 3'b010;
      do_tick();
      check_val("rs_rest_gnd", bus.grounded, 1);
      bus.lines = 3'b001;
      for (int i = 0; i < 6; i++) begin
         do_tick();
         show("fall");
         check_val("fall_height", bus.height, fall_h[i]);
         check_val("fall_vel", bus.velocity, fall_v[i]);
      end
      for (int i = 0; i < 40 && !bus.grounded; i++) do_tick();
      show("land_down");
      check_val("land_dn_gnd", bus.grounded, 1);
      check_val("land_dn_height", bus.height, 120);
      check_val("land_dn_vel", bus.velocity, 0);

      // Fall out with freeze in the middle
      pulse_restart();
      bus.lines = 3'b000;
      for (int i = 0; i < 4; i++) do_tick();
      show("pre_freeze");
      check_val("pf_height", bus.height, 230);
      bus.is_dead = 1'b1;
      bus.flip_req = 1'b1;
      for (int i = 0; i < 8; i++) do_tick();
      show("frozen");
      check_val("frz_height", bus.height, 230);
      check_val("frz_vel", bus.velocity, -4);
      check_val("frz_ack", bus.flip_ack, 0);
      bus.is_dead = 1'b0;
      bus.flip_req = 1'b0;
      do_tick();
      show("resume");
      check_val("resume_height", bus.height, 226);
      check_val("resume_vel", bus.velocity, -4);
      for (int i = 0; i < 80 && !bus.out_of_bounds; i++) do_tick();
      show("fell_out");
      check_val("oob_flag", bus.out_of_bounds, 1);
      check_val("oob_height", bus.height, 2);
      check_val("oob_vel", bus.velocity, 0);
      bus.lines = 3'b111;
      for (int i = 0; i < 3; i++) do_tick();
      check_val("oob_hold_h", bus.height, 2);
      check_val("oob_hold_f", bus.out_of_bounds, 1);
      pulse_restart();
      show("restart2");
      check_val("rs2_height", bus.height, 240);
      check_val("rs2_oob", bus.out_of_bounds, 0);

      // Asynchronous reset mid-rise at 250
      bus.lines = 3'b010;
      do_tick();
      pulse_flip();
      bus.lines = 3'b111;
      for (int i = 0; i < 4; i++) do_tick();
      check_val("ar_pre_height", bus.height, 250);
      #3 rst_n = 1'b0;
      #1;
      show("async_rst");
      check_val("ar_height", bus.height, 240);
      check_val("ar_grav", bus.grav_up, 0);
      check_val("ar_vel", bus.velocity, 0);
      @(negedge clk) rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
